// File: rtl/combined_module_if.sv
// Flow-meter classifier bus: sensor reading in, band indicator and mid-range flag out.
// The master drives flow_rate; the classifier (slave) returns y and z.
interface combined_module_if #(
   parameter int FLOW_W = 6
);
   logic [FLOW_W-1:0] flow_rate;
   logic [4:0]        y;
   logic              z;

   modport master (output flow_rate, input y, input z);
   modport slave  (input flow_rate, output y, output z);
endinterface

// File: rtl/combined_module.sv
// Flow-meter classifier: registers a one-hot band code (bands of STEP L/min, top band saturating)
// and an inclusive mid-range window flag for the flow reading sampled each clock.
module combined_module #(
   parameter int FLOW_W = 6,
   parameter int STEP   = 10,
   parameter int Z_LO   = 20,
   parameter int Z_HI   = 50
) (
   input logic              clk,
   input logic              rst_n,
   combined_module_if.slave bus
);

   // Thresholds are guaranteed to fit FLOW_W by the elaboration check below.
   localparam logic [FLOW_W-1:0] TH1     = FLOW_W'(STEP * 1);
   localparam logic [FLOW_W-1:0] TH2     = FLOW_W'(STEP * 2);
   localparam logic [FLOW_W-1:0] TH3     = FLOW_W'(STEP * 3);
   localparam logic [FLOW_W-1:0] TH4     = FLOW_W'(STEP * 4);
   localparam logic [FLOW_W-1:0] TH5     = FLOW_W'(STEP * 5);
   localparam logic [FLOW_W-1:0] Z_LO_C  = FLOW_W'(Z_LO);
   localparam logic [FLOW_W-1:0] Z_HI_C  = FLOW_W'(Z_HI);

   generate
      if ((STEP * 5) > ((2 ** FLOW_W) - 1)) begin : g_bad_step
         $error("combined_module: STEP*5 exceeds the flow_rate range");
      end
   endgenerate

   logic [4:0] y_s;
   logic       z_s;
   logic [4:0] y_r;
   logic       z_r;

   // Band decode and window compare on the current reading.
   always_comb begin
      y_s = 5'b00000;
      z_s = 1'b0;
      if (bus.flow_rate >= TH5) begin
         y_s = 5'b10000;
      end else if (bus.flow_rate >= TH4) begin
         y_s = 5'b01000;
      end else if (bus.flow_rate >= TH3) begin
         y_s = 5'b00100;
      end else if (bus.flow_rate >= TH2) begin
         y_s = 5'b00010;
      end else if (bus.flow_rate >= TH1) begin
         y_s = 5'b00001;
      end else begin
         y_s = 5'b00000;
      end
      if ((bus.flow_rate >= Z_LO_C) && (bus.flow_rate <= Z_HI_C)) begin
         z_s = 1'b1;
      end else begin
         z_s = 1'b0;
      end
   end

   // Output registers; reset clears them without waiting for a clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_r <= 5'b00000;
         z_r <= 1'b0;
      end else begin
         y_r <= y_s;
         z_r <= z_s;
      end
   end

   assign bus.y = y_r;
   assign bus.z = z_r;

endmodule

// File: tb/tb_combined_module.sv
// Self-checking bench for combined_module: directed vector table, reset sequences,
// and a full/random sweep against an independent band model.
`timescale 1ns/1ps
module tb_combined_module;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_bad;

   combined_module_if #(.FLOW_W(6)) bus ();

   combined_module #(.FLOW_W(6), .STEP(10), .Z_LO(20), .Z_HI(50)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [5:0] flow;
      logic [4:0] y;
      logic       z;
   } vec_t;

   vec_t vecs[15];

   task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
      n_cmp = n_cmp + 1;
      if (act !== exp) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   // Drive a reading between edges, then sample just after the capturing edge.
   task automatic apply(input logic [5:0] flow);
      @(negedge clk);
      bus.flow_rate = flow;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [4:0] model_y(input int r);
      logic [4:0] one;
      one = 5'b00001;
      if (r < 10) return 5'b00000;
      if (r >= 50) return 5'b10000;
      return one << ((r / 10) - 1);
   endfunction

   function automatic logic model_z(input int r);
      return (r >= 20) && (r <= 50);
   endfunction

   initial begin
      n_cmp = 0;
      n_bad = 0;
      vecs[0]  = '{6'd5,  5'b00000, 1'b0};
      vecs[1]  = '{6'd12, 5'b00001, 1'b0};
      vecs[2]  = '{6'd25, 5'b00010, 1'b1};
      vecs[3]  = '{6'd35, 5'b00100, 1'b1};
      vecs[4]  = '{6'd45, 5'b01000, 1'b1};
      vecs[5]  = '{6'd55, 5'b10000, 1'b0};
      vecs[6]  = '{6'd9,  5'b00000, 1'b0};
      vecs[7]  = '{6'd10, 5'b00001, 1'b0};
      vecs[8]  = '{6'd19, 5'b00001, 1'b0};
      vecs[9]  = '{6'd20, 5'b00010, 1'b1};
      vecs[10] = '{6'd49, 5'b01000, 1'b1};
      vecs[11] = '{6'd50, 5'b10000, 1'b1};
      vecs[12] = '{6'd51, 5'b10000, 1'b0};
      vecs[13] = '{6'd63, 5'b10000, 1'b0};
      vecs[14] = '{6'd0,  5'b00000, 1'b0};

      // Reset held low with a live reading: outputs stay cleared across edges.
      rst_n = 1'b0;
      bus.flow_rate = 6'd45;
      repeat (3) @(posedge clk);
      #1;
      check("reset_y", bus.y, 5'b00000);
      check("reset_z", {4'b0000, bus.z}, 5'b00000);
      @(negedge clk);
      bus.flow_rate = 6'd5;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_reset_y", bus.y, 5'b00000);
      check("post_reset_z", {4'b0000, bus.z}, 5'b00000);

      // Directed table.
      for (int i = 0; i < 15; i++) begin
         apply(vecs[i].flow);
         check($sformatf("vec%0d_y(r=%0d)", i, vecs[i].flow), bus.y, vecs[i].y);
         check($sformatf("vec%0d_z(r=%0d)", i, vecs[i].flow), {4'b0000, bus.z}, {4'b0000, vecs[i].z});
      end

      // Mid-stream reset: clears between edges, then resumes on next edge.
      apply(6'd25);
      check("pre_mid_reset_y", bus.y, 5'b00010);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_reset_y", bus.y, 5'b00000);
      check("mid_reset_z", {4'b0000, bus.z}, 5'b00000);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("after_mid_reset_y", bus.y, 5'b00010);
      check("after_mid_reset_z", {4'b0000, bus.z}, 5'b00001);

      // Full ascending sweep followed by random readings.
      for (int k = 0; k < 104; k++) begin
         int r;
         r = (k < 64) ? k : int'($urandom_range(0, 63));
         apply(6'(r));
         check($sformatf("sweep_y(r=%0d)", r), bus.y, model_y(r));
         check($sformatf("sweep_z(r=%0d)", r), {4'b0000, bus.z}, {4'b0000, model_z(r)});
         check($sformatf("onehot(r=%0d)", r), 5'($countones(bus.y) <= 1), 5'b00001);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
